// File: rtl/bcd_serial_add_ctrl_pkg.sv
// Shared definitions for the digit-serial BCD adder controller:
// state encoding and BCD digit constants.
package bcd_serial_add_ctrl_pkg;

   localparam int DIGIT_W  = 4;
   localparam int BCD_MAX  = 9;
   localparam int BCD_CORR = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_ADD  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/bcd_serial_add_ctrl_digit_add.sv
// One-digit BCD adder cell: x + y + ci with decimal correction, plus a flag
// for operand digits outside 0..9.
module bcd_digit_add
   import bcd_serial_add_ctrl_pkg::*;
(
   input  logic [DIGIT_W-1:0] x,
   input  logic [DIGIT_W-1:0] y,
   input  logic               ci,
   output logic [DIGIT_W-1:0] d,
   output logic               co,
   output logic               bad
);

   localparam int SW = DIGIT_W + 1;

   logic [SW-1:0] s;
   logic [SW-1:0] s_corr;

   always_comb begin
      s      = {1'b0, x} + {1'b0, y} + {{DIGIT_W{1'b0}}, ci};
      // 5-bit wrap of s+6 leaves the low nibble equal to (s+6) mod 16
      s_corr = s + SW'(BCD_CORR);
      if (s > SW'(BCD_MAX)) begin
         d  = s_corr[DIGIT_W-1:0];
         co = 1'b1;
      end else begin
         d  = s[DIGIT_W-1:0];
         co = 1'b0;
      end
      bad = (x > DIGIT_W'(BCD_MAX)) || (y > DIGIT_W'(BCD_MAX));
   end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD adder controller: captures two NDIGITS-digit operands on
// start and adds them LSD first through one shared digit cell.
module bcd_serial_add_ctrl
   import bcd_serial_add_ctrl_pkg::*;
#(
   parameter int NDIGITS = 4
) (
   input  logic                   CLOCK_50,
   input  logic                   RESETN,
   input  logic                   start,
   input  logic                   cin,
   input  logic [4*NDIGITS-1:0]   a,
   input  logic [4*NDIGITS-1:0]   b,
   output logic                   busy,
   output logic                   done,
   output logic [4*NDIGITS-1:0]   sum,
   output logic                   cout,
   output logic                   err
);

   localparam int W     = DIGIT_W * NDIGITS;
   localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIGITS - 1);

   state_t             state_q, state_d;
   logic [W-1:0]       a_q, a_d;
   logic [W-1:0]       b_q, b_d;
   logic [W-1:0]       sum_q, sum_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d;
   logic               cout_q, cout_d;
   logic               err_q, err_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [DIGIT_W-1:0] a_dig, b_dig, dig;
   logic               dig_co, dig_bad;

   always_comb begin
      a_dig = '0;
      b_dig = '0;
      for (int i = 0; i < NDIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            a_dig = a_q[i*DIGIT_W +: DIGIT_W];
            b_dig = b_q[i*DIGIT_W +: DIGIT_W];
         end
      end
   end

   bcd_digit_add u_digit (
      .x   (a_dig),
      .y   (b_dig),
      .ci  (carry_q),
      .d   (dig),
      .co  (dig_co),
      .bad (dig_bad)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      err_d   = err_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               err_d   = 1'b0;
               idx_d   = '0;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: state_d = ST_ADD;
         ST_ADD: begin
            for (int i = 0; i < NDIGITS; i++) begin
               if (idx_q == IDX_W'(i)) sum_d[i*DIGIT_W +: DIGIT_W] = dig;
            end
            carry_d = dig_co;
            err_d   = err_q | dig_bad;
            idx_d   = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
               cout_d  = dig_co;
               idx_d   = '0;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Status flags are registered from the next state so they align with it
      busy_d = (state_d == ST_LOAD) || (state_d == ST_ADD);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge CLOCK_50 or negedge RESETN) begin
      if (!RESETN) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
   assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for bcd_serial_add_ctrl with NDIGITS=4, using a
// decimal-arithmetic reference model and randomized operands.
module tb_bcd_serial_add_ctrl;

   localparam int N = 4;
   localparam int W = 4 * N;

   logic          CLOCK_50 = 1'b0;
   logic          RESETN;
   logic          start;
   logic          cin;
   logic [W-1:0]  a, b;
   logic          busy, done, cout, err;
   logic [W-1:0]  sum;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLOCK_50 = ~CLOCK_50;

   bcd_serial_add_ctrl #(.NDIGITS(N)) dut (
      .CLOCK_50 (CLOCK_50),
      .RESETN   (RESETN),
      .start    (start),
      .cin      (cin),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .cout     (cout),
      .err      (err)
   );

   // Valid operands: plain decimal addition. Invalid digits: per-digit rule.
   function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mc, output logic [W-1:0] es,
                                 output logic ec, output logic ee);
      int da, db, lim, tot, c, s, ai, bi;
      ee = 1'b0;
      es = '0;
      ec = 1'b0;
      for (int i = 0; i < N; i++)
         if (int'(ma[4*i +: 4]) > 9 || int'(mb[4*i +: 4]) > 9) ee = 1'b1;
      if (!ee) begin
         da = 0; db = 0; lim = 1;
         for (int i = N - 1; i >= 0; i--) begin
            da  = da * 10 + int'(ma[4*i +: 4]);
            db  = db * 10 + int'(mb[4*i +: 4]);
            lim = lim * 10;
         end
         tot = da + db + int'(mc);
         ec  = (tot >= lim);
         tot = tot % lim;
         for (int i = 0; i < N; i++) begin
            es[4*i +: 4] = 4'(tot % 10);
            tot = tot / 10;
         end
      end else begin
         c = int'(mc);
         for (int i = 0; i < N; i++) begin
            ai = int'(ma[4*i +: 4]);
            bi = int'(mb[4*i +: 4]);
            s  = ai + bi + c;
            if (s > 9) begin
               es[4*i +: 4] = 4'((s + 6) % 16);
               c = 1;
            end else begin
               es[4*i +: 4] = 4'(s);
               c = 0;
            end
         end
         ec = (c != 0);
      end
   endfunction

   function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
      logic [W-1:0] v;
      for (int i = 0; i < N; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
      if (allow_bad && $urandom_range(0, 3) == 0)
         v[4*$urandom_range(0, N-1) +: 4] = 4'($urandom_range(10, 15));
      return v;
   endfunction

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb2,
                         input logic tc, input string nm);
      logic [W-1:0] es, got_s;
      logic         ec, ee, got_c, got_e;
      int           busy_cnt, done_cnt, done_at;
      model(ta, tb2, tc, es, ec, ee);
      busy_cnt = 0; done_cnt = 0; done_at = -1;
      got_s = '0; got_c = 1'b0; got_e = 1'b0;
      @(posedge CLOCK_50); #1;
      a = ta; b = tb2; cin = tc; start = 1'b1;
      @(posedge CLOCK_50); #1;
      start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      for (int n = 0; n <= N + 4; n++) begin
         if (n > 0) begin @(posedge CLOCK_50); #1; end
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++; done_at = n;
            got_s = sum; got_c = cout; got_e = err;
         end
      end
      n_checks++;
      if (done_at !== N + 1) begin n_fail++; $display("FAIL %s done_edge: got %0d expected %0d", nm, done_at, N + 1); end
      n_checks++;
      if (done_cnt !== 1) begin n_fail++; $display("FAIL %s done_pulses: got %0d expected 1", nm, done_cnt); end
      n_checks++;
      if (busy_cnt !== N + 1) begin n_fail++; $display("FAIL %s busy_cycles: got %0d expected %0d", nm, busy_cnt, N + 1); end
      n_checks++;
      if (got_s !== es) begin n_fail++; $display("FAIL %s sum: got %h expected %h", nm, got_s, es); end
      n_checks++;
      if (got_c !== ec) begin n_fail++; $display("FAIL %s cout: got %b expected %b", nm, got_c, ec); end
      n_checks++;
      if (got_e !== ee) begin n_fail++; $display("FAIL %s err: got %b expected %b", nm, got_e, ee); end
   endtask

   task automatic test_reset();
      RESETN = 1'b0; start = 1'b0; cin = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge CLOCK_50);
      #1;
      n_checks++;
      if ({busy, done, cout, err} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, cout, err}); end
      n_checks++;
      if (sum !== '0) begin n_fail++; $display("FAIL reset_sum: got %h expected 0", sum); end
      RESETN = 1'b1;
      @(posedge CLOCK_50); #1;
      n_checks++;
      if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL idle_flags: got %b expected 00", {busy, done}); end
   endtask

   task automatic test_vectors();
      run_op(16'h1234, 16'h5678, 1'b0, "basic");
      run_op(16'h9999, 16'h0000, 1'b1, "ripple");
      run_op(16'h00A0, 16'h0005, 1'b0, "invalid");
      run_op(16'h0450, 16'h0321, 1'b0, "err_clear");
   endtask

   task automatic test_random();
      for (int k = 0; k < 10; k++)
         run_op(rand_bcd(1'b1), rand_bcd(1'b1), 1'($urandom), "random");
   endtask

   task automatic test_back_to_back();
      int done_ns[$];
      @(posedge CLOCK_50); #1;
      a = 16'h0001; b = 16'h0001; cin = 1'b0; start = 1'b1;
      @(posedge CLOCK_50); #1;
      for (int n = 0; n <= 22; n++) begin
         if (n > 0) begin @(posedge CLOCK_50); #1; end
         if ((n % 7) >= 1 && (n % 7) <= 3) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
         end else begin
            a = 16'h0001; b = 16'h0001; cin = 1'b0;
         end
         if (done) begin
            done_ns.push_back(n);
            n_checks++;
            if ({cout, sum} !== {1'b0, 16'h0002}) begin n_fail++; $display("FAIL b2b_result: got %b/%h expected 0/0002", cout, sum); end
         end
      end
      start = 1'b0;
      repeat (N + 4) @(posedge CLOCK_50);
      #1;
      n_checks++;
      if (done_ns.size() !== 3) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 3", done_ns.size()); end
      if (done_ns.size() >= 3) begin
         n_checks++;
         if (done_ns[0] !== N + 1) begin n_fail++; $display("FAIL b2b_first_done: got %0d expected %0d", done_ns[0], N + 1); end
         n_checks++;
         if ((done_ns[1] - done_ns[0]) !== N + 3 || (done_ns[2] - done_ns[1]) !== N + 3) begin
            n_fail++; $display("FAIL b2b_spacing: got %0d,%0d expected %0d", done_ns[1] - done_ns[0], done_ns[2] - done_ns[1], N + 3);
         end
      end
   endtask

   task automatic test_start_in_done();
      int viol;
      logic saw_done;
      viol = 0; saw_done = 1'b0;
      @(posedge CLOCK_50); #1;
      a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
      @(posedge CLOCK_50); #1;
      start = 1'b0;
      for (int n = 0; n <= N + 8; n++) begin
         if (n > 0) begin @(posedge CLOCK_50); #1; end
         if (n == N + 1) begin
            saw_done = done;
            a = rand_bcd(1'b0); b = rand_bcd(1'b0); start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (n >= N + 2 && (busy || done)) viol++;
      end
      n_checks++;
      if (saw_done !== 1'b1) begin n_fail++; $display("FAIL done_cycle_seen: got %b expected 1", saw_done); end
      n_checks++;
      if (viol !== 0) begin n_fail++; $display("FAIL start_in_done_ignored: got %0d active cycles expected 0", viol); end
      n_checks++;
      if (sum !== 16'h6912) begin n_fail++; $display("FAIL start_in_done_sum_hold: got %h expected 6912", sum); end
   endtask

   task automatic test_reset_mid();
      int viol;
      viol = 0;
      run_op(16'h9999, 16'h0000, 1'b1, "pre_reset");
      @(posedge CLOCK_50); #1;
      a = 16'h123A; b = 16'h5678; cin = 1'b0; start = 1'b1;
      @(posedge CLOCK_50); #1;
      start = 1'b0;
      repeat (3) @(posedge CLOCK_50);
      #1;
      n_checks++;
      if ({busy, err, cout} !== 3'b111) begin n_fail++; $display("FAIL mid_op_state: got %b expected 111", {busy, err, cout}); end
      RESETN = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, cout, err} !== 4'b0000) begin n_fail++; $display("FAIL async_reset_flags: got %b expected 0000", {busy, done, cout, err}); end
      n_checks++;
      if (sum !== '0) begin n_fail++; $display("FAIL async_reset_sum: got %h expected 0", sum); end
      @(posedge CLOCK_50); #1;
      RESETN = 1'b1;
      repeat (N + 6) begin
         @(posedge CLOCK_50); #1;
         if (busy || done) viol++;
      end
      n_checks++;
      if (viol !== 0) begin n_fail++; $display("FAIL aborted_no_done: got %0d active cycles expected 0", viol); end
      run_op(16'h4321, 16'h1111, 1'b0, "after_reset");
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_random();
      test_back_to_back();
      test_start_in_done();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_serial_add_ctrl.md
Name: bcd_serial_add_ctrl

Overview:
- Digit-serial BCD adder controller for the multi-digit BCD adder on the DE2 switch/7-seg lab platform.
- Captures two NDIGITS-digit BCD operands on a start request and adds them one digit per cycle, least significant digit first.
- Reuses a single one-digit BCD adder cell, holding the digit carry between cycles.
- Presents a registered result with a one-cycle done pulse, a carry-out and an invalid-digit error flag. The result feeds the existing 7-segment decoders.

Parameters:
NDIGITS, 4, number of BCD digits per operand; legal range 1..8

Ports:
CLOCK_50  in  1  system clock, rising edge
RESETN  in  1  asynchronous active-low reset
start  in  1  request to begin an addition; sampled only in IDLE
cin  in  1  carry into digit 0; captured with the operands
a  in  4*NDIGITS  operand A, BCD, digit i at bits [4i+3:4i]
b  in  4*NDIGITS  operand B, same packing
busy  out  1  high while in LOAD or ADD
done  out  1  single-cycle pulse when sum/cout/err are valid
sum  out  4*NDIGITS  registered BCD result
cout  out  1  carry out of the most significant digit
err  out  1  some operand digit was greater than 9 in the last operation

Behaviour:
- Reset (RESETN low, asynchronous): state=IDLE, busy=0, done=0, sum=0, cout=0, err=0, digit index=0, carry=0, operand registers=0.
- Reset mid-operation aborts the operation immediately; after release the block is in IDLE and the aborted operation produces no done pulse.
- States: IDLE, LOAD, ADD, DONE.
- IDLE:
  - start=1 at an edge: capture a, b and cin; clear err; set index=0; go to LOAD.
  - start=0: remain in IDLE; sum, cout and err hold their last values.
- LOAD: one cycle; busy=1; goes to ADD unconditionally. This separates operand capture from the first digit operation.
- ADD, one digit per edge:
  - Compute digit i from the operand registers and the carry register; write it into sum[4i+3:4i]; update the carry register.
  - err |= (a_i>9) | (b_i>9).
  - index increments. On the edge that processes index NDIGITS-1: cout <= digit carry; go to DONE.
- DONE: one cycle; done=1, busy=0; go to IDLE. start is ignored in DONE.
- Latency, with start sampled at edge k:
  - LOAD during cycle k..k+1.
  - Digit i written at edge k+2+i.
  - done=1 in the cycle after edge k+1+NDIGITS.
  - Next start is accepted at edge k+NDIGITS+3 at the earliest.
- start while busy or in DONE is ignored; it is not queued.
- Operand inputs may change freely after the capture edge without affecting the result.
- Digit arithmetic:
  - s = a_i + b_i + c, as a 5-bit value in the range 0..31.
  - If s>9: digit = (s+6) mod 16, carry=1. Otherwise digit = s, carry=0.
  - This rule is deterministic for invalid inputs too; err flags that case.
- sum is updated digit by digit during ADD. Consumers sample sum only on done.
- Outputs are all registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package: state encoding constants (IDLE=0, LOAD=1, ADD=2, DONE=3), BCD_MAX=9, BCD_CORR=6, DIGIT_W=4.
- One combinational sub-module, bcd_digit_add:
  - Inputs: x[3:0], y[3:0], ci.
  - Outputs: d[3:0], co, bad (x>9 or y>9).
  - Instantiated once by the controller, which selects operand digits by index.

Test Plan (NDIGITS=4):
- a=0x1234, b=0x5678, cin=0, start pulsed at edge k -> done high only in the cycle after edge k+5; sum=0x6912, cout=0, err=0; busy high for exactly 5 cycles.
- a=0x9999, b=0x0000, cin=1 -> sum=0x0000, cout=1, err=0. This ripples the carry through all digits.
- a=0x00A0, b=0x0005, cin=0 -> err=1; sum=0x0105 per the digit rule (A+0=10 -> 0, carry 1); cout=0. A following valid operation clears err.
- start held high continuously with a=0x0001, b=0x0001 -> ops complete with sum=0x0002. done pulses are spaced NDIGITS+3=7 cycles apart. Operand changes during ADD do not alter the result.
- RESETN pulsed low during ADD digit 2 -> busy, done, sum, cout and err go to 0 immediately with no clock edge required. No done pulse follows; the next start completes normally.
- start asserted in the DONE cycle only -> ignored; the block returns to IDLE and sum holds.
